// File: rtl/dino_pkg.sv
// dino_pkg: register map and widths shared by the status readback block and vga_ball.
package dino_pkg;
  localparam logic [2:0] REG_STATUS    = 3'd0;
  localparam logic [2:0] REG_SCORE     = 3'd1;
  localparam logic [2:0] REG_HISCORE   = 3'd2;
  localparam logic [2:0] REG_SPEED     = 3'd3;
  localparam logic [2:0] REG_FRAME_CNT = 3'd4;
  localparam logic [2:0] REG_GAMES     = 3'd5;
  localparam logic [2:0] REG_IRQ_CTRL  = 3'd6;
  localparam logic [2:0] REG_IRQ_STAT  = 3'd7;
  localparam int HACTIVE = 1280;
  localparam int VACTIVE = 480;
  localparam int SCORE_W = 17;
  localparam int SPEED_W = 11;
  localparam int CTRL_W  = 8;
endpackage

// File: rtl/dino_status_readback_if.sv
// dino_status_readback_if: Avalon-MM slave bus with interrupt line.
interface dino_status_readback_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output chipselect, read, write, address, writedata, input readdata, irq);
  modport slave  (input chipselect, read, write, address, writedata, output readdata, irq);
endinterface

// File: rtl/dino_status_readback_frame_snap_strobe.sv
// frame_snap_strobe: one-cycle pulse at the start of the snapshot line.
module frame_snap_strobe #(
  parameter int VSNAP = 480
) (
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        snap
);
  assign snap = (vcount == 10'(VSNAP)) && (hcount == 11'd0);
endmodule

// File: rtl/dino_status_readback.sv
// dino_status_readback: per-frame coherent snapshot of game state, readable over Avalon, with game-over IRQ.
module dino_status_readback
  import dino_pkg::*;
#(
  parameter int VSNAP   = 480,
  parameter int GAMES_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  dino_status_readback_if.slave bus,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  input  logic [SCORE_W-1:0]   score,
  input  logic                 game_over,
  input  logic [SPEED_W-1:0]   obstacle_speed,
  input  logic [CTRL_W-1:0]    controller_report
);
  logic                 snap, rd_en, wr_en, go_edge, w1c, hi_clr;
  logic [31:0]          rd_mux, readdata_d, readdata_q;
  logic [SCORE_W-1:0]   score_d, score_q, hiscore_d, hiscore_q;
  logic [SPEED_W-1:0]   speed_d, speed_q;
  logic [CTRL_W-1:0]    ctrl_d, ctrl_q;
  logic [31:0]          frame_cnt_d, frame_cnt_q;
  logic [GAMES_W-1:0]   games_d, games_q;
  logic                 go_snap_d, go_snap_q, game_over_q;
  logic                 irq_en_d, irq_en_q, irq_pend_d, irq_pend_q, irq_d, irq_q;
  logic                 unused;

  frame_snap_strobe #(.VSNAP(VSNAP)) u_snap (.hcount(hcount), .vcount(vcount), .snap(snap));

  assign unused = ^bus.writedata[31:1];
  assign rd_en  = bus.chipselect & bus.read;
  assign wr_en  = bus.chipselect & bus.write;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      REG_STATUS:    rd_mux = {16'd0, ctrl_q, 6'd0, irq_pend_q, go_snap_q};
      REG_SCORE:     rd_mux = 32'(score_q);
      REG_HISCORE:   rd_mux = 32'(hiscore_q);
      REG_SPEED:     rd_mux = 32'(speed_q);
      REG_FRAME_CNT: rd_mux = frame_cnt_q;
      REG_GAMES:     rd_mux = 32'(games_q);
      REG_IRQ_CTRL:  rd_mux = {31'd0, irq_en_q};
      default:       rd_mux = {31'd0, irq_pend_q};
    endcase
    go_edge     = game_over & ~game_over_q;
    w1c         = wr_en && bus.address == REG_IRQ_STAT && bus.writedata[0];
    hi_clr      = wr_en && bus.address == REG_HISCORE;
    readdata_d  = rd_en ? rd_mux : readdata_q;
    score_d     = snap ? score : score_q;
    speed_d     = snap ? obstacle_speed : speed_q;
    ctrl_d      = snap ? controller_report : ctrl_q;
    go_snap_d   = snap ? game_over : go_snap_q;
    frame_cnt_d = snap ? frame_cnt_q + 32'd1 : frame_cnt_q;
    // A software clear beats a same-cycle snapshot; the compare resumes next frame.
    hiscore_d   = hi_clr ? '0 : (snap && score > hiscore_q) ? score : hiscore_q;
    games_d     = (go_edge && ~&games_q) ? games_q + GAMES_W'(1) : games_q;
    irq_en_d    = (wr_en && bus.address == REG_IRQ_CTRL) ? bus.writedata[0] : irq_en_q;
    irq_pend_d  = go_edge ? 1'b1 : w1c ? 1'b0 : irq_pend_q;
    irq_d       = irq_pend_q & irq_en_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q  <= '0;
      score_q     <= '0;
      speed_q     <= '0;
      ctrl_q      <= '0;
      go_snap_q   <= 1'b0;
      frame_cnt_q <= '0;
      hiscore_q   <= '0;
      games_q     <= '0;
      irq_en_q    <= 1'b0;
      irq_pend_q  <= 1'b0;
      irq_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      readdata_q  <= readdata_d;
      score_q     <= score_d;
      speed_q     <= speed_d;
      ctrl_q      <= ctrl_d;
      go_snap_q   <= go_snap_d;
      frame_cnt_q <= frame_cnt_d;
      hiscore_q   <= hiscore_d;
      games_q     <= games_d;
      irq_en_q    <= irq_en_d;
      irq_pend_q  <= irq_pend_d;
      irq_q       <= irq_d;
      game_over_q <= game_over;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;
endmodule
